led_arbiter: RTL and testbench
==============================

// Module: led_arbiter
// PURPOSE
//  Shares the single cartridge LED between all status sources: per-source activity strobes, a busy/boot blink
//  request and an error blink-code. Fixed priority ERR > BLINK > ACT. Replaces direct LED drive by peripherals;
//  sits between the peripheral status outputs and the LED pin.
// PARAMETERS
//  NUM_SRC     2           number of activity sources; index 0 = highest priority for ActSrc reporting
//  DELAY       21_480_000  activity stretch after last ActReq [clk]
//  BLINK       2_148_000   busy-blink period [clk]; on for first BLINK/2 cycles
//  CODE_PULSE  5_370_000   error-code on time and inter-pulse off time [clk]
//  CODE_GAP    21_480_000  off time after last pulse of a code before repeat [clk]
//  PWM_BITS    4           dimming PWM resolution (LED_PWM_DIM_EN only)
// PORTS
//  CLK         in   1                  clock
//  RESET_n     in   1                  reset, asynchronous, active-low
//  ActReq      in   NUM_SRC            activity level/strobe per source
//  BlinkReq    in   1                  level: busy/boot blink requested
//  ErrValid    in   1                  pulse: latch ErrCode
//  ErrCode     in   4                  error code = pulse count 1..15; 0 ignored
//  ErrClear    in   1                  pulse: end error display
//  DimLevel    in   PWM_BITS           ACT brightness duty (LED_PWM_DIM_EN only)
//  LedPort     out  1                  LED drive, registered, 1 = lit
//  Owner       out  2                  led_pkg::LED_OWNER_t: OWN_IDLE/OWN_ACT/OWN_BLINK/OWN_ERR
//  ActSrc      out  $clog2(NUM_SRC)    lowest-index source of most recent ActReq
//  ErrActive   out  1                  error code being displayed
// BEHAVIOUR
//  Reset: LedPort=0, Owner=OWN_IDLE, ActSrc=0, ErrActive=0, FSM=ST_IDLE, all timers 0.
//  Stretch timer runs independently of FSM: any ActReq bit high -> load DELAY, ActSrc <= lowest set index;
//   else decrement to 0 and hold. Activity during BLINK/ERR is not lost; it decays in the background.
//  FSM states: ST_IDLE, ST_ACT, ST_BLINK, ST_ERR_ON, ST_ERR_OFF, ST_ERR_GAP. Re-arbitrated every cycle:
//   ErrActive -> ERR states; else BlinkReq -> ST_BLINK; else stretch!=0 -> ST_ACT; else ST_IDLE.
//  ACT: ActReq high in cycle k -> LedPort=1 from cycle k+1; LedPort falls exactly DELAY cycles after last ActReq.
//  BLINK: phase counter restarts at 0 on entry, wraps at BLINK-1; LedPort=(phase<BLINK/2). BlinkReq drop ->
//   next cycle to ST_ACT if stretch!=0 else ST_IDLE; LedPort follows same cycle as state.
//  ERR: ErrValid with ErrCode!=0 latches code, sets ErrActive; if no sequence running, start at ST_ERR_ON with
//   pulse count = code. Sequence: ON CODE_PULSE, OFF CODE_PULSE (skipped after last pulse), GAP CODE_GAP, repeat.
//   ErrValid while active: new code stored, takes effect at next ST_ERR_ON after GAP (no truncated sequence).
//   ErrClear: ErrActive=0, LedPort=0 next cycle, mid-pulse abort allowed, re-arbitrate. ErrClear wins over ErrValid
//   in same cycle. ErrCode=0 with ErrValid: ignored entirely.
//  Preemption mid-phase (e.g. error during blink): lower-priority phase state discarded; blink restarts at phase 0.
//  Reset mid-operation: all state to reset values immediately (async); no sequence resumes.
//  Counter widths: $clog2(max+1) of respective parameter; no overflow, no wrap except phase/PWM counters.
// CONFIGURATION
//  LED_PWM_DIM_EN defined: DimLevel port present; free-running PWM_BITS counter; in OWN_ACT
//   LedPort = stretch_on && (pwm_cnt < DimLevel); DimLevel=0 -> dark, all-ones -> 1/2^PWM_BITS short of full.
//   BLINK/ERR always full brightness.
//  Not defined: DimLevel port and PWM counter absent; ACT is full brightness.
// STRUCTURE
//  led_pkg: LED_OWNER_t enum, LED_FSM_t state enum, ERR_CODE_W=4 constant.
//  Sub-module led_timer: loadable down-counter (WIDTH param; Load, Value, Dec; Zero flag); instantiated for
//   stretch timer and ERR/BLINK sequence timer.
// TESTING (bench params: NUM_SRC=2 DELAY=10 BLINK=8 CODE_PULSE=3 CODE_GAP=6 PWM_BITS=2)
//  1. ActReq=2'b10 one cycle at k -> LedPort=1 cycles k+1..k+10, ActSrc=1, Owner=OWN_ACT, then OWN_IDLE.
//  2. BlinkReq=1 for 20 cycles -> LedPort pattern 1111_0000 repeating from entry; drop with ActReq 3 cycles
//     earlier -> ST_ACT, LedPort=1 until 10 cycles after that ActReq.
//  3. ErrValid, ErrCode=2 -> on3 off3 on3 gap6 repeat, ErrActive=1; ErrClear mid 2nd on -> LedPort=0 next cycle.
//  4. Error during blink, BlinkReq still 1 -> error preempts; after ErrClear blink restarts at phase 0.
//  5. ErrValid code=3 during GAP of code 2 -> current gap completes, next sequence 3 pulses; same-cycle
//     ErrValid+ErrClear -> ErrActive=0; ErrCode=0 -> no change.
//  6. RESET_n low mid ST_ERR_ON -> LedPort=0, Owner=OWN_IDLE immediately; with LED_PWM_DIM_EN, DimLevel=1
//     -> LedPort duty 1/4 during ACT.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and constants for the cartridge LED arbiter.
package led_pkg;

   localparam int ERR_CODE_W = 4;

   typedef enum logic [1:0] {
      OWN_IDLE  = 2'd0,
      OWN_ACT   = 2'd1,
      OWN_BLINK = 2'd2,
      OWN_ERR   = 2'd3
   } LED_OWNER_t;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ACT     = 3'd1,
      ST_BLINK   = 3'd2,
      ST_ERR_ON  = 3'd3,
      ST_ERR_OFF = 3'd4,
      ST_ERR_GAP = 3'd5
   } LED_FSM_t;

   // Largest of three durations, used to size the shared sequence timer.
   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/led_timer.sv
// Loadable down-counter that holds at zero. Next_o exposes the value the
// counter takes at the coming edge so callers can register outputs that
// line up with the new count.
module led_timer
   import led_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RESET_n,
   input  logic             Load_i,
   input  logic [WIDTH-1:0] Value_i,
   input  logic             Dec_i,
   output logic [WIDTH-1:0] Next_o,
   output logic             Zero_o
);

   logic [WIDTH-1:0] count_q, count_d;

   // Load has priority over decrement; decrement stops at zero.
   always_comb begin
      count_d = count_q;
      if (Load_i) begin
         count_d = Value_i;
      end else if (Dec_i && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   // Count register.
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign Next_o = count_d;
   assign Zero_o = (count_q == '0);

endmodule

// File: rtl/led_arbiter.sv
// Cartridge LED arbiter: fixed priority ERR > BLINK > ACT over one LED.
// Optional feature macro: LED_PWM_DIM_EN adds DimLevel_i and PWM dimming
// of the activity indication; without it activity is full brightness.
module led_arbiter
   import led_pkg::*;
#(
   parameter int  NUM_SRC    = 2,
   parameter int  DELAY      = 21_480_000,
   parameter int  BLINK      = 2_148_000,
   parameter int  CODE_PULSE = 5_370_000,
   parameter int  CODE_GAP   = 21_480_000,
   parameter int  PWM_BITS   = 4,
   localparam int SRC_W      = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
   input  logic                  CLK,
   input  logic                  RESET_n,
   input  logic [NUM_SRC-1:0]    ActReq_i,
   input  logic                  BlinkReq_i,
   input  logic                  ErrValid_i,
   input  logic [ERR_CODE_W-1:0] ErrCode_i,
   input  logic                  ErrClear_i,
`ifdef LED_PWM_DIM_EN
   input  logic [PWM_BITS-1:0]   DimLevel_i,
`endif
   output logic                  LedPort_o,
   output LED_OWNER_t            Owner_o,
   output logic [SRC_W-1:0]      ActSrc_o,
   output logic                  ErrActive_o
);

   localparam int STR_W = $clog2(DELAY + 1);
   localparam int SEQ_W = $clog2(max3(BLINK, CODE_PULSE, CODE_GAP) + 1);
   // Sequence timer reload values count the remaining cycles of a phase.
   localparam logic [SEQ_W-1:0] BLINK_LD  = SEQ_W'(BLINK - 1);
   localparam logic [SEQ_W-1:0] PULSE_LD  = SEQ_W'(CODE_PULSE - 1);
   localparam logic [SEQ_W-1:0] GAP_LD    = SEQ_W'(CODE_GAP - 1);
   // Blink phase = BLINK-1-count, so "phase < BLINK/2" becomes this bound.
   localparam logic [SEQ_W-1:0] BLINK_MIN = SEQ_W'(BLINK - BLINK / 2);

   LED_FSM_t              state_q, state_d;
   logic                  led_q, led_d;
   logic [SRC_W-1:0]      act_src_q, act_src_d;
   logic                  err_active_q, err_active_d;
   logic [ERR_CODE_W-1:0] code_q, code_d;
   logic [ERR_CODE_W-1:0] pulses_q, pulses_d;
   logic [STR_W-1:0]      stretch_next;
   logic                  stretch_zero_unused;
   logic                  seq_load, seq_dec, seq_zero;
   logic [SEQ_W-1:0]      seq_value, seq_next;

   led_timer #(.WIDTH(STR_W)) u_stretch (
      .CLK     (CLK),
      .RESET_n (RESET_n),
      .Load_i  (|ActReq_i),
      .Value_i (STR_W'(DELAY)),
      .Dec_i   (1'b1),
      .Next_o  (stretch_next),
      .Zero_o  (stretch_zero_unused)
   );

   led_timer #(.WIDTH(SEQ_W)) u_seq (
      .CLK     (CLK),
      .RESET_n (RESET_n),
      .Load_i  (seq_load),
      .Value_i (seq_value),
      .Dec_i   (seq_dec),
      .Next_o  (seq_next),
      .Zero_o  (seq_zero)
   );

   // Error latch: clear beats a same-cycle valid; code 0 is ignored.
   always_comb begin
      err_active_d = err_active_q;
      code_d       = code_q;
      if (ErrClear_i) begin
         err_active_d = 1'b0;
      end else if (ErrValid_i && (ErrCode_i != '0)) begin
         err_active_d = 1'b1;
         code_d       = ErrCode_i;
      end
   end

   // Activity source: lowest set index wins, otherwise keep the last one.
   always_comb begin
      act_src_d = act_src_q;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (ActReq_i[i]) begin
            act_src_d = SRC_W'(i);
         end
      end
   end

   // Arbitration and phase sequencing, re-evaluated every cycle.
   always_comb begin
      state_d   = state_q;
      pulses_d  = pulses_q;
      seq_load  = 1'b0;
      seq_dec   = 1'b0;
      seq_value = PULSE_LD;
      if (err_active_d) begin
         if (!err_active_q) begin
            state_d  = ST_ERR_ON;
            seq_load = 1'b1;
            pulses_d = code_d;
         end else begin
            case (state_q)
               ST_ERR_ON: begin
                  if (seq_zero) begin
                     seq_load = 1'b1;
                     if (pulses_q <= ERR_CODE_W'(1)) begin
                        state_d   = ST_ERR_GAP;
                        seq_value = GAP_LD;
                     end else begin
                        state_d  = ST_ERR_OFF;
                        pulses_d = pulses_q - 1'b1;
                     end
                  end else begin
                     seq_dec = 1'b1;
                  end
               end
               ST_ERR_OFF: begin
                  if (seq_zero) begin
                     state_d  = ST_ERR_ON;
                     seq_load = 1'b1;
                  end else begin
                     seq_dec = 1'b1;
                  end
               end
               ST_ERR_GAP: begin
                  // A code stored during the sequence is picked up only here.
                  if (seq_zero) begin
                     state_d  = ST_ERR_ON;
                     seq_load = 1'b1;
                     pulses_d = code_d;
                  end else begin
                     seq_dec = 1'b1;
                  end
               end
               default: begin
                  state_d  = ST_ERR_ON;
                  seq_load = 1'b1;
                  pulses_d = code_d;
               end
            endcase
         end
      end else if (BlinkReq_i) begin
         state_d   = ST_BLINK;
         seq_value = BLINK_LD;
         if ((state_q != ST_BLINK) || seq_zero) begin
            seq_load = 1'b1;
         end else begin
            seq_dec = 1'b1;
         end
      end else if (stretch_next != '0) begin
         state_d = ST_ACT;
      end else begin
         state_d = ST_IDLE;
      end
   end

`ifdef LED_PWM_DIM_EN
   logic [PWM_BITS-1:0] pwm_q;

   // Free-running dimming counter.
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         pwm_q <= '0;
      end else begin
         pwm_q <= pwm_q + 1'b1;
      end
   end
`else
   logic pwm_bits_unused;
   assign pwm_bits_unused = (PWM_BITS > 0);
`endif

   // LED level for the state being entered, so LED and state change together.
   always_comb begin
      led_d = 1'b0;
      case (state_d)
         ST_ERR_ON: led_d = 1'b1;
         ST_BLINK:  led_d = (seq_next >= BLINK_MIN);
`ifdef LED_PWM_DIM_EN
         ST_ACT:    led_d = (pwm_q < DimLevel_i);
`else
         ST_ACT:    led_d = 1'b1;
`endif
         default:   led_d = 1'b0;
      endcase
   end

   // State and output registers.
   always_ff @(posedge CLK or negedge RESET_n) begin
      if (!RESET_n) begin
         state_q      <= ST_IDLE;
         led_q        <= 1'b0;
         act_src_q    <= '0;
         err_active_q <= 1'b0;
         code_q       <= '0;
         pulses_q     <= '0;
      end else begin
         state_q      <= state_d;
         led_q        <= led_d;
         act_src_q    <= act_src_d;
         err_active_q <= err_active_d;
         code_q       <= code_d;
         pulses_q     <= pulses_d;
      end
   end

   // Owner is a direct decode of the current state.
   always_comb begin
      case (state_q)
         ST_ACT:                            Owner_o = OWN_ACT;
         ST_BLINK:                          Owner_o = OWN_BLINK;
         ST_ERR_ON, ST_ERR_OFF, ST_ERR_GAP: Owner_o = OWN_ERR;
         default:                           Owner_o = OWN_IDLE;
      endcase
   end

   assign LedPort_o   = led_q;
   assign ActSrc_o    = act_src_q;
   assign ErrActive_o = err_active_q;

endmodule

// File: tb/tb_led_arbiter.sv
// Self-checking bench for led_arbiter with small timing parameters.
// Expected behaviour comes from a time-based model: each owner's LED level is
// computed from the cycle at which its activity/blink/error sequence began.
module tb_led_arbiter;
   import led_pkg::*;

   localparam int NUM_SRC    = 2;
   localparam int DELAY      = 10;
   localparam int BLINK      = 8;
   localparam int CODE_PULSE = 3;
   localparam int CODE_GAP   = 6;
   localparam int PWM_BITS   = 2;

   logic       CLK      = 1'b0;
   logic       RESET_n  = 1'b0;
   logic [1:0] ActReq   = '0;
   logic       BlinkReq = 1'b0;
   logic       ErrValid = 1'b0;
   logic [3:0] ErrCode  = '0;
   logic       ErrClear = 1'b0;
`ifdef LED_PWM_DIM_EN
   logic [1:0] DimLevel = 2'b11;
`endif
   logic       LedPort;
   LED_OWNER_t Owner;
   logic       ActSrc;
   logic       ErrActive;

   int total = 0;
   int bad   = 0;

   // Reference model state (times are cycle numbers since reset release).
   int         t, act_t, seq_start, seq_code, code_m, blink_start;
   bit         err_m, blink_m;
   logic       src_m;
   logic       exp_led;
   LED_OWNER_t exp_own;

   always #5 CLK = ~CLK;

   led_arbiter #(
      .NUM_SRC(NUM_SRC), .DELAY(DELAY), .BLINK(BLINK),
      .CODE_PULSE(CODE_PULSE), .CODE_GAP(CODE_GAP), .PWM_BITS(PWM_BITS)
   ) dut (
      .CLK        (CLK),
      .RESET_n    (RESET_n),
      .ActReq_i   (ActReq),
      .BlinkReq_i (BlinkReq),
      .ErrValid_i (ErrValid),
      .ErrCode_i  (ErrCode),
      .ErrClear_i (ErrClear),
`ifdef LED_PWM_DIM_EN
      .DimLevel_i (DimLevel),
`endif
      .LedPort_o  (LedPort),
      .Owner_o    (Owner),
      .ActSrc_o   (ActSrc),
      .ErrActive_o(ErrActive)
   );

   function automatic int seq_len(input int n);
      return (2 * n - 1) * CODE_PULSE + CODE_GAP;
   endfunction

   task automatic model_eval();
      int p;
      if (err_m) begin
         p       = t - seq_start;
         exp_own = OWN_ERR;
         exp_led = (p < (2 * seq_code - 1) * CODE_PULSE) && (((p / CODE_PULSE) % 2) == 0);
      end else if (blink_m) begin
         exp_own = OWN_BLINK;
         exp_led = ((t - blink_start) % BLINK) < (BLINK / 2);
      end else if (t - act_t < DELAY) begin
         exp_own = OWN_ACT;
`ifdef LED_PWM_DIM_EN
         exp_led = ((t - 1) % (1 << PWM_BITS)) < int'(DimLevel);
`else
         exp_led = 1'b1;
`endif
      end else begin
         exp_own = OWN_IDLE;
         exp_led = 1'b0;
      end
   endtask

   task automatic model_reset();
      t = 0; act_t = -1000; seq_start = 0; seq_code = 1; code_m = 0;
      blink_start = 0; err_m = 0; blink_m = 0; src_m = 1'b0;
      model_eval();
   endtask

   // Drive one cycle of inputs, clock it, advance the model.
   task automatic step(input logic [1:0] act, input logic blink, input logic ev,
                       input logic [3:0] code, input logic clr);
      ActReq = act; BlinkReq = blink; ErrValid = ev; ErrCode = code; ErrClear = clr;
      @(posedge CLK);
      #1;
      t++;
      if (act != 2'b00) begin
         act_t = t;
         src_m = act[0] ? 1'b0 : 1'b1;
      end
      if (clr) begin
         err_m = 0;
      end else if (ev && (code != 4'd0)) begin
         if (!err_m) begin
            err_m     = 1;
            seq_start = t;
            seq_code  = int'(code);
         end
         code_m = int'(code);
      end
      if (err_m && (t - seq_start >= seq_len(seq_code))) begin
         seq_start = seq_start + seq_len(seq_code);
         seq_code  = code_m;
      end
      if (err_m || !blink) begin
         blink_m = 0;
      end else if (!blink_m) begin
         blink_m     = 1;
         blink_start = t;
      end
      model_eval();
   endtask

   task automatic test_reset();
      #2;
      total++;
      if ({LedPort, Owner, ErrActive, ActSrc} !== {1'b0, OWN_IDLE, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL reset_state got led=%b own=%0d err=%b src=%b want 0/0/0/0", LedPort, Owner, ErrActive, ActSrc);
      end
      @(posedge CLK);
      #1;
      RESET_n = 1'b1;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         step(2'b00, 0, 0, 4'd0, 0);
         total++;
         if ({LedPort, Owner, ErrActive, ActSrc} !== {exp_led, exp_own, err_m, src_m}) begin
            bad++;
            $display("FAIL reset_idle t=%0d got %b/%0d/%b/%b want %b/%0d/%b/%b", t, LedPort, Owner, ErrActive, ActSrc, exp_led, exp_own, err_m, src_m);
         end
      end
      $display("test_reset done t=%0d", t);
   endtask

   task automatic test_act();
      step(2'b10, 0, 0, 4'd0, 0);
      for (int i = 1; i <= 12; i++) begin
         if (i > 1) step(2'b00, 0, 0, 4'd0, 0);
         total++;
         if (LedPort !== exp_led || ActSrc !== 1'b1 ||
             Owner !== ((i <= DELAY) ? OWN_ACT : OWN_IDLE) || (i > DELAY && LedPort !== 1'b0)) begin
            bad++;
            $display("FAIL act_stretch i=%0d got led=%b own=%0d src=%b want led=%b own=%0d src=1", i, LedPort, Owner, ActSrc, exp_led, (i <= DELAY) ? 1 : 0);
         end
      end
      $display("test_act done t=%0d", t);
   endtask

   task automatic test_blink();
      for (int i = 0; i < 20; i++) begin
         step((i == 16) ? 2'b01 : 2'b00, 1, 0, 4'd0, 0);
         total++;
         if (LedPort !== ((i % BLINK) < BLINK / 2) || Owner !== OWN_BLINK ||
             {LedPort, Owner, ErrActive, ActSrc} !== {exp_led, exp_own, err_m, src_m}) begin
            bad++;
            $display("FAIL blink_pattern i=%0d got led=%b own=%0d want led=%b own=2", i, LedPort, Owner, (i % BLINK) < BLINK / 2);
         end
      end
      for (int i = 0; i < 10; i++) begin
         step(2'b00, 0, 0, 4'd0, 0);
         total++;
         if ({LedPort, Owner, ErrActive, ActSrc} !== {exp_led, exp_own, err_m, src_m}) begin
            bad++;
            $display("FAIL blink_drop t=%0d got %b/%0d/%b/%b want %b/%0d/%b/%b", t, LedPort, Owner, ErrActive, ActSrc, exp_led, exp_own, err_m, src_m);
         end
      end
      $display("test_blink done t=%0d", t);
   endtask

   task automatic test_err();
      int n;
      step(2'b00, 0, 1, 4'd2, 0);
      for (int i = 0; i < 40; i++) begin
         total++;
         if ({LedPort, Owner, ErrActive, ActSrc} !== {exp_led, exp_own, err_m, src_m}) begin
            bad++;
            $display("FAIL err_seq t=%0d got %b/%0d/%b/%b want %b/%0d/%b/%b", t, LedPort, Owner, ErrActive, ActSrc, exp_led, exp_own, err_m, src_m);
         end
         step(2'b00, 0, 0, 4'd0, 0);
      end
      n = 0;
      while ((t - seq_start) != 7 && n < 20) begin
         step(2'b00, 0, 0, 4'd0, 0);
         n++;
      end
      total++;
      if (n >= 20 || LedPort !== 1'b1 || ErrActive !== 1'b1) begin
         bad++;
         $display("FAIL err_second_on n=%0d got led=%b err=%b want led=1 err=1", n, LedPort, ErrActive);
      end
      step(2'b00, 0, 0, 4'd0, 1);
      total++;
      if (LedPort !== 1'b0 || ErrActive !== 1'b0 || Owner !== OWN_IDLE) begin
         bad++;
         $display("FAIL err_clear got led=%b err=%b own=%0d want 0/0/0", LedPort, ErrActive, Owner);
      end
      $display("test_err done t=%0d", t);
   endtask

   task automatic test_preempt();
      for (int i = 0; i < 5; i++) step(2'b00, 1, 0, 4'd0, 0);
      step(2'b00, 1, 1, 4'd1, 0);
      for (int i = 0; i < 12; i++) begin
         total++;
         if ({LedPort, Owner, ErrActive, ActSrc} !== {exp_led, exp_own, err_m, src_m}) begin
            bad++;
            $display("FAIL preempt_err t=%0d got %b/%0d/%b/%b want %b/%0d/%b/%b", t, LedPort, Owner, ErrActive, ActSrc, exp_led, exp_own, err_m, src_m);
         end
         step(2'b00, 1, 0, 4'd0, 0);
      end
      step(2'b00, 1, 0, 4'd0, 1);
      for (int i = 0; i < 8; i++) begin
         total++;
         if (LedPort !== (i < BLINK / 2) || Owner !== OWN_BLINK || ErrActive !== 1'b0) begin
            bad++;
            $display("FAIL preempt_restart i=%0d got led=%b own=%0d err=%b want led=%b own=2 err=0", i, LedPort, Owner, ErrActive, i < BLINK / 2);
         end
         step(2'b00, 1, 0, 4'd0, 0);
      end
      for (int i = 0; i < 3; i++) step(2'b00, 0, 0, 4'd0, 0);
      $display("test_preempt done t=%0d", t);
   endtask

   task automatic test_err_update();
      int n, lit;
      step(2'b00, 0, 1, 4'd2, 0);
      n = 0;
      while ((t - seq_start) != 10 && n < 20) begin
         step(2'b00, 0, 0, 4'd0, 0);
         n++;
      end
      step(2'b00, 0, 1, 4'd3, 0);
      for (int i = 0; i < 4; i++) begin
         total++;
         if (LedPort !== 1'b0 || ErrActive !== 1'b1 || n >= 20) begin
            bad++;
            $display("FAIL upd_gap_kept i=%0d got led=%b err=%b want led=0 err=1", i, LedPort, ErrActive);
         end
         step(2'b00, 0, 0, 4'd0, 0);
      end
      lit = 0;
      for (int i = 0; i < seq_len(3); i++) begin
         total++;
         if ({LedPort, Owner, ErrActive, ActSrc} !== {exp_led, exp_own, err_m, src_m}) begin
            bad++;
            $display("FAIL upd_seq t=%0d got %b/%0d/%b/%b want %b/%0d/%b/%b", t, LedPort, Owner, ErrActive, ActSrc, exp_led, exp_own, err_m, src_m);
         end
         lit += int'(LedPort);
         step(2'b00, 0, 0, 4'd0, 0);
      end
      total++;
      if (lit != 3 * CODE_PULSE) begin
         bad++;
         $display("FAIL upd_pulse_count got lit=%0d want %0d", lit, 3 * CODE_PULSE);
      end
      step(2'b00, 0, 1, 4'd5, 1);
      total++;
      if (ErrActive !== 1'b0 || LedPort !== 1'b0) begin
         bad++;
         $display("FAIL clear_beats_valid got err=%b led=%b want 0/0", ErrActive, LedPort);
      end
      for (int i = 0; i < 3; i++) begin
         step(2'b00, 0, 1, 4'd0, 0);
         total++;
         if (ErrActive !== 1'b0 || Owner !== OWN_IDLE || LedPort !== 1'b0) begin
            bad++;
            $display("FAIL code_zero_ignored got err=%b own=%0d led=%b want 0/0/0", ErrActive, Owner, LedPort);
         end
      end
      $display("test_err_update done t=%0d", t);
   endtask

   task automatic test_random();
      logic       blk;
      logic [1:0] act;
      blk = 1'b0;
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 39) == 0) blk = ~blk;
         act = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'b00;
`ifdef LED_PWM_DIM_EN
         if ($urandom_range(0, 49) == 0) DimLevel = 2'($urandom);
`endif
         step(act, blk, ($urandom_range(0, 59) == 0), 4'($urandom_range(0, 15)),
              ($urandom_range(0, 99) == 0));
         total++;
         if ({LedPort, Owner, ErrActive, ActSrc} !== {exp_led, exp_own, err_m, src_m}) begin
            bad++;
            $display("FAIL random t=%0d got %b/%0d/%b/%b want %b/%0d/%b/%b", t, LedPort, Owner, ErrActive, ActSrc, exp_led, exp_own, err_m, src_m);
         end
      end
      step(2'b00, 0, 0, 4'd0, 1);
`ifdef LED_PWM_DIM_EN
      DimLevel = 2'b11;
`endif
      $display("test_random done t=%0d", t);
   endtask

   task automatic test_async_reset();
      step(2'b10, 0, 1, 4'd2, 0);
      step(2'b00, 0, 0, 4'd0, 0);
      #2;
      RESET_n = 1'b0;
      #1;
      total++;
      if ({LedPort, Owner, ErrActive, ActSrc} !== {1'b0, OWN_IDLE, 1'b0, 1'b0}) begin
         bad++;
         $display("FAIL async_reset got led=%b own=%0d err=%b src=%b want 0/0/0/0", LedPort, Owner, ErrActive, ActSrc);
      end
      @(posedge CLK);
      #1;
      RESET_n = 1'b1;
      model_reset();
      for (int i = 0; i < 20; i++) begin
         step(2'b00, 0, 0, 4'd0, 0);
         total++;
         if ({LedPort, Owner, ErrActive, ActSrc} !== {exp_led, exp_own, err_m, src_m}) begin
            bad++;
            $display("FAIL reset_no_resume t=%0d got %b/%0d/%b/%b want %b/%0d/%b/%b", t, LedPort, Owner, ErrActive, ActSrc, exp_led, exp_own, err_m, src_m);
         end
      end
      $display("test_async_reset done t=%0d", t);
   endtask

`ifdef LED_PWM_DIM_EN
   task automatic test_pwm();
      int lit;
      DimLevel = 2'd1;
      lit = 0;
      for (int i = 0; i < 40; i++) begin
         step((i % 5 == 0) ? 2'b01 : 2'b00, 0, 0, 4'd0, 0);
         total++;
         if ({LedPort, Owner} !== {exp_led, exp_own}) begin
            bad++;
            $display("FAIL pwm_cycle t=%0d got led=%b own=%0d want led=%b own=%0d", t, LedPort, Owner, exp_led, exp_own);
         end
         lit += int'(LedPort);
      end
      total++;
      if (lit != 10) begin
         bad++;
         $display("FAIL pwm_duty got lit=%0d want 10", lit);
      end
      DimLevel = 2'd0;
      for (int i = 0; i < 8; i++) begin
         step(2'b01, 0, 0, 4'd0, 0);
         total++;
         if (LedPort !== 1'b0 || Owner !== OWN_ACT) begin
            bad++;
            $display("FAIL pwm_dark got led=%b own=%0d want led=0 own=1", LedPort, Owner);
         end
      end
      DimLevel = 2'b11;
      $display("test_pwm done t=%0d", t);
   endtask
`endif

   initial begin
      test_reset();
      test_act();
      test_blink();
      test_err();
      test_preempt();
      test_err_update();
      test_random();
      test_async_reset();
`ifdef LED_PWM_DIM_EN
      test_pwm();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
